// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the PC/fetch controller.
package pc_pkg;
    typedef enum logic [1:0] {BOOT, ISSUE, STALL, HOLD} pc_state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_FLUSH, SRC_BRANCH} redir_src_e;
    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC00000;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one flush slot plus one branch slot holding redirects
// that arrive while a fetch request is waiting to be accepted.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic             clear_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] flush_pc_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_pc_i,
    output logic [1:0]       src_o,
    output logic [WIDTH-1:0] pc_o
);
    logic             fl_v_q, fl_v_d, br_v_q, br_v_d;
    logic [WIDTH-1:0] fl_pc_q, fl_pc_d, br_pc_q, br_pc_d;

    // A flush kills any branch; a branch behind a pending flush is dropped.
    always_comb begin
        fl_v_d  = fl_v_q;
        fl_pc_d = fl_pc_q;
        br_v_d  = br_v_q;
        br_pc_d = br_pc_q;
        if (clear_i) begin
            fl_v_d = 1'b0;
            br_v_d = 1'b0;
        end else if (capture_i && flush_i) begin
            fl_v_d  = 1'b1;
            fl_pc_d = flush_pc_i;
            br_v_d  = 1'b0;
        end else if (capture_i && branch_i && !fl_v_q) begin
            br_v_d  = 1'b1;
            br_pc_d = branch_pc_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_v_q  <= 1'b0;
            br_v_q  <= 1'b0;
            fl_pc_q <= '0;
            br_pc_q <= '0;
        end else begin
            fl_v_q  <= fl_v_d;
            br_v_q  <= br_v_d;
            fl_pc_q <= fl_pc_d;
            br_pc_q <= br_pc_d;
        end
    end

    assign src_o = fl_v_q ? SRC_FLUSH : br_v_q ? SRC_BRANCH : SRC_NONE;
    assign pc_o  = fl_v_q ? fl_pc_q : br_pc_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and fetch-request FSM with prioritised redirects.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets into HOLD.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int               STEP         = PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] flush_pc_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_pc_i,
    output logic             if_req_o,
    output logic [WIDTH-1:0] if_addr_o,
    input  logic             if_ready_i,
    output logic             fetch_valid_o,
    output logic [WIDTH-1:0] fetch_pc_o,
    output logic             adel_o,
    output logic [WIDTH-1:0] badvaddr_o
);
    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d, fetch_pc_q, fetch_pc_d, tgt, pend_pc;
    logic             fetch_valid_q, fetch_valid_d, accept, capture, redir, load, is_flush;
    logic [1:0]       pend_src;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    logic             adel_q, adel_d;
    logic [WIDTH-1:0] badvaddr_q, badvaddr_d;
`endif

    assign accept  = (state_q == ISSUE) && if_ready_i;
    assign capture = (state_q == ISSUE) && !if_ready_i;

    pc_redirect_buf #(.WIDTH(WIDTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .capture_i  (capture),
        .clear_i    (accept),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .branch_i   (branch_i),
        .branch_pc_i(branch_pc_i),
        .src_o      (pend_src),
        .pc_o       (pend_pc)
    );

    always_comb begin
        state_d  = state_q;
        tgt      = addr_q + WIDTH'(STEP);
        redir    = 1'b0;
        load     = 1'b0;
        is_flush = 1'b0;
        case (state_q)
            BOOT: state_d = ISSUE;
            ISSUE: if (if_ready_i) begin
                is_flush = flush_i || (pend_src == SRC_FLUSH);
                redir    = is_flush || branch_i || (pend_src == SRC_BRANCH);
                load     = 1'b1;
                tgt      = flush_i ? flush_pc_i :
                           (pend_src == SRC_FLUSH) ? pend_pc :
                           branch_i ? branch_pc_i :
                           (pend_src == SRC_BRANCH) ? pend_pc : addr_q + WIDTH'(STEP);
                state_d  = (stall_i && !is_flush) ? STALL : ISSUE;
            end
            STALL: begin
                redir   = flush_i || branch_i;
                load    = redir;
                tgt     = flush_i ? flush_pc_i : branch_pc_i;
                state_d = (flush_i || !stall_i) ? ISSUE : STALL;
            end
            HOLD: begin
                redir   = flush_i;
                load    = redir;
                tgt     = flush_pc_i;
                state_d = flush_i ? ISSUE : HOLD;
            end
            default: state_d = BOOT;
        endcase
        addr_d        = load ? tgt : addr_q;
        fetch_valid_d = accept;
        fetch_pc_d    = accept ? addr_q : fetch_pc_q;
`ifdef PC_ALIGN_CHECK_EN
        adel_d     = 1'b0;
        badvaddr_d = badvaddr_q;
        // A misaligned target is never issued; the PC parks until a flush.
        if (redir && |(tgt & ALIGN_MASK)) begin
            adel_d     = 1'b1;
            badvaddr_d = tgt;
            addr_d     = addr_q;
            state_d    = HOLD;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            addr_q        <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= RESET_VECTOR;
`ifdef PC_ALIGN_CHECK_EN
            adel_q        <= 1'b0;
            badvaddr_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
`ifdef PC_ALIGN_CHECK_EN
            adel_q        <= adel_d;
            badvaddr_q    <= badvaddr_d;
`endif
        end
    end

    assign if_req_o      = (state_q == ISSUE);
    assign if_addr_o     = addr_q;
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_pc_o    = fetch_pc_q;
`ifdef PC_ALIGN_CHECK_EN
    assign adel_o        = adel_q;
    assign badvaddr_o    = badvaddr_q;
`else
    assign adel_o        = 1'b0;
    assign badvaddr_o    = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table, hand-written corner sequences and
// a randomized run against a queue-based reference model.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        stall_i = 0, flush_i = 0, branch_i = 0, if_ready_i = 0;
    logic [31:0] flush_pc_i = 0, branch_pc_i = 0;
    logic        if_req_o, fetch_valid_o, adel_o;
    logic [31:0] if_addr_o, fetch_pc_o, badvaddr_o;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .branch_i     (branch_i),
        .branch_pc_i  (branch_pc_i),
        .if_req_o     (if_req_o),
        .if_addr_o    (if_addr_o),
        .if_ready_i   (if_ready_i),
        .fetch_valid_o(fetch_valid_o),
        .fetch_pc_o   (fetch_pc_o),
        .adel_o       (adel_o),
        .badvaddr_o   (badvaddr_o)
    );

    typedef struct {
        logic        stall, flush;
        logic [31:0] fpc;
        logic        branch;
        logic [31:0] bpc;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] fetch_pc;
    } vec_t;

    typedef struct {
        bit          fl;
        logic [31:0] pc;
    } red_t;

    // Reference model: redirects seen while a request waits are kept in
    // arrival order and resolved only when the request is accepted.
    red_t        pq[$];
    int          m_mode;  // 0 boot, 1 requesting, 2 stalled, 3 held
    logic [31:0] m_addr, m_fpc, m_bad;
    bit          m_fv, m_adel;

    function automatic logic [98:0] pk(logic r, logic [31:0] a, logic v, logic [31:0] p,
                                       logic d, logic [31:0] b);
        return {r, a, v, p, d, b};
    endfunction

    task automatic chk(string nm, logic [98:0] act, logic [98:0] exp, logic [98:0] msk);
        tests++;
        if ((act & msk) !== (exp & msk)) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act & msk, exp & msk);
        end
    endtask

    task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        pq.delete();
        m_mode = 0; m_addr = RV; m_fpc = RV; m_fv = 0; m_adel = 0; m_bad = 0;
    endtask

    task automatic m_step();
        bit          acc = (m_mode == 1) && if_ready_i;
        bit          redir = 0, isfl = 0, hf = 0, hb = 0;
        int          nmode = m_mode;
        logic [31:0] nxt = m_addr + 32'd4, naddr = m_addr, lf = 0, lb = 0;
        case (m_mode)
            0: nmode = 1;
            1: if (!if_ready_i) begin
                if (branch_i) pq.push_back('{0, branch_pc_i});
                if (flush_i) pq.push_back('{1, flush_pc_i});
            end else begin
                foreach (pq[k]) begin
                    if (pq[k].fl) begin hf = 1; lf = pq[k].pc; end
                    else begin hb = 1; lb = pq[k].pc; end
                end
                if (flush_i) begin nxt = flush_pc_i; redir = 1; isfl = 1; end
                else if (hf) begin nxt = lf; redir = 1; isfl = 1; end
                else if (branch_i) begin nxt = branch_pc_i; redir = 1; end
                else if (hb) begin nxt = lb; redir = 1; end
                pq.delete();
                naddr = nxt;
                nmode = (stall_i && !isfl) ? 2 : 1;
            end
            2: begin
                if (flush_i || branch_i) begin
                    redir = 1; nxt = flush_i ? flush_pc_i : branch_pc_i; naddr = nxt;
                end
                nmode = (flush_i || !stall_i) ? 1 : 2;
            end
            default: if (flush_i) begin redir = 1; nxt = flush_pc_i; naddr = nxt; nmode = 1; end
        endcase
        m_adel = 0;
`ifdef PC_ALIGN_CHECK_EN
        if (redir && nxt[1:0] != 2'b00) begin
            m_adel = 1; m_bad = nxt; naddr = m_addr; nmode = 3;
        end
`endif
        m_fv = acc;
        if (acc) m_fpc = m_addr;
        m_addr = naddr;
        m_mode = nmode;
    endtask

    function automatic logic [31:0] rpc();
        return ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
    endfunction

    vec_t tbl[21];
    logic [98:0] all_m, hold_m;

    initial begin
        all_m  = '1;
        hold_m = ~({67'd0, 32'hFFFFFFFF} << 66);
        //            stall fl fpc           br bpc           rdy  req addr          fv fetch_pc
        tbl[0]  = '{0, 0, 32'h0,         0, 32'h0,         1,   0, RV,           0, RV};
        tbl[1]  = '{0, 0, 32'h0,         0, 32'h0,         1,   1, RV,           0, RV};
        tbl[2]  = '{0, 0, 32'h0,         0, 32'h0,         0,   1, 32'hBFC00004, 1, RV};
        tbl[3]  = '{0, 0, 32'h0,         1, 32'h80001000,  0,   1, 32'hBFC00004, 0, RV};
        tbl[4]  = '{0, 0, 32'h0,         0, 32'h0,         0,   1, 32'hBFC00004, 0, RV};
        tbl[5]  = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'hBFC00004, 0, RV};
        tbl[6]  = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h80001000, 1, 32'hBFC00004};
        tbl[7]  = '{0, 0, 32'h0,         1, 32'h80002000,  0,   1, 32'h80001004, 1, 32'h80001000};
        tbl[8]  = '{0, 1, 32'hBFC00380,  0, 32'h0,         0,   1, 32'h80001004, 0, 32'h80001000};
        tbl[9]  = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h80001004, 0, 32'h80001000};
        tbl[10] = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'hBFC00380, 1, 32'h80001004};
        tbl[11] = '{1, 0, 32'h0,         0, 32'h0,         1,   1, 32'hBFC00384, 1, 32'hBFC00380};
        tbl[12] = '{1, 0, 32'h0,         0, 32'h0,         1,   0, 32'hBFC00388, 1, 32'hBFC00384};
        tbl[13] = '{1, 0, 32'h0,         0, 32'h0,         0,   0, 32'hBFC00388, 0, 32'hBFC00384};
        tbl[14] = '{1, 1, 32'hBFC00380,  0, 32'h0,         0,   0, 32'hBFC00388, 0, 32'hBFC00384};
        tbl[15] = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'hBFC00380, 0, 32'hBFC00384};
        tbl[16] = '{0, 1, 32'hFFFFFFF8,  0, 32'h0,         1,   1, 32'hBFC00384, 1, 32'hBFC00380};
        tbl[17] = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'hFFFFFFF8, 1, 32'hBFC00384};
        tbl[18] = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'hFFFFFFFC, 1, 32'hFFFFFFF8};
        tbl[19] = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h00000000, 1, 32'hFFFFFFFC};
        tbl[20] = '{0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h00000004, 1, 32'h00000000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 21; i++) begin
            stall_i = tbl[i].stall; flush_i = tbl[i].flush; flush_pc_i = tbl[i].fpc;
            branch_i = tbl[i].branch; branch_pc_i = tbl[i].bpc; if_ready_i = tbl[i].ready;
            #1;
            chk($sformatf("vec%0d", i),
                pk(if_req_o, if_addr_o, fetch_valid_o, fetch_pc_o, adel_o, badvaddr_o),
                pk(tbl[i].req, tbl[i].addr, tbl[i].fv, tbl[i].fetch_pc, 1'b0, 32'h0), all_m);
            @(posedge clk); #1;
        end

        // Misaligned branch target
        stall_i = 0; flush_i = 0; branch_i = 1; branch_pc_i = 32'h80001002; if_ready_i = 1;
        @(posedge clk); #1;
        branch_i = 0;
`ifdef PC_ALIGN_CHECK_EN
        chk32("adel_pulse", 32'(adel_o), 32'd1);
        chk32("badvaddr", badvaddr_o, 32'h80001002);
        chk32("hold_req", 32'(if_req_o), 32'd0);
        @(posedge clk); #1;
        chk32("adel_one_cycle", 32'(adel_o), 32'd0);
        chk32("hold_req2", 32'(if_req_o), 32'd0);
        chk32("badvaddr_kept", badvaddr_o, 32'h80001002);
`else
        chk32("unaligned_addr", if_addr_o, 32'h80001002);
        chk32("adel_tied", 32'(adel_o), 32'd0);
        chk32("badvaddr_tied", badvaddr_o, 32'd0);
        @(posedge clk); #1;
        chk32("unaligned_seq", if_addr_o, 32'h80001006);
`endif
        flush_i = 1; flush_pc_i = 32'hBFC00380;
        @(posedge clk); #1;
        flush_i = 0;
        chk32("resume_req", 32'(if_req_o), 32'd1);
        chk32("resume_addr", if_addr_o, 32'hBFC00380);

        // Async reset mid-request discards a captured branch
        if_ready_i = 0; branch_i = 1; branch_pc_i = 32'h80004000;
        @(posedge clk); #1;
        branch_i = 0;
        #2 rst = 1;
        #1;
        chk("async_rst", pk(if_req_o, if_addr_o, fetch_valid_o, fetch_pc_o, adel_o, badvaddr_o),
            pk(1'b0, RV, 1'b0, RV, 1'b0, 32'h0), all_m);
        @(posedge clk); #1;
        rst = 0; if_ready_i = 1;
        @(posedge clk); #1;
        chk32("post_rst_addr0", if_addr_o, RV);
        @(posedge clk); #1;
        chk32("post_rst_no_branch", if_addr_o, 32'hBFC00004);

        // Randomized run against the reference model
        rst = 1; if_ready_i = 0;
        m_reset();
        @(posedge clk); #1;
        rst = 0;
        chk("rand_reset", pk(if_req_o, if_addr_o, fetch_valid_o, fetch_pc_o, adel_o, badvaddr_o),
            pk(1'b0, m_addr, m_fv, m_fpc, m_adel, m_bad), all_m);
        for (int c = 0; c < 3000; c++) begin
            stall_i     = ($urandom_range(0, 3) == 0);
            flush_i     = ($urandom_range(0, 9) == 0);
            flush_pc_i  = rpc();
            branch_i    = ($urandom_range(0, 5) == 0);
            branch_pc_i = rpc();
            if_ready_i  = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            m_step();
            #1;
            chk($sformatf("rand%0d", c),
                pk(if_req_o, if_addr_o, fetch_valid_o, fetch_pc_o, adel_o, badvaddr_o),
                pk(m_mode == 1, m_addr, m_fv, m_fpc, m_adel, m_bad),
                (m_mode == 3) ? hold_m : all_m);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter and fetch-request controller for the MIPS pipeline front end. It replaces the plain enable/clear PC register with these additions:
- a valid/ready handshake towards the instruction-fetch port;
- prioritised redirect sources (exception flush, branch/jump);
- a pending-redirect buffer so redirects arriving while a fetch is outstanding are never lost;
- an optional misaligned-target check.

It sits between the hazard/exception units and the I-cache/I-SRAM interface.

## Interface
Parameters:
- WIDTH, 32, PC/address width
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset
- STEP, 4, sequential increment in bytes; power of two

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hazard-unit stall; blocks issue of new fetches
- flush_i  in  1  exception/eret redirect; highest priority
- flush_pc_i  in  WIDTH  flush target
- branch_i  in  1  branch/jump redirect
- branch_pc_i  in  WIDTH  branch target
- if_req_o  out  1  fetch request valid
- if_addr_o  out  WIDTH  fetch address
- if_ready_i  in  1  fetch port accepts request this cycle
- fetch_valid_o  out  1  one-cycle pulse: the fetch at fetch_pc_o was accepted last cycle
- fetch_pc_o  out  WIDTH  address of the last accepted fetch
- adel_o  out  1  misaligned redirect target detected (pulse)
- badvaddr_o  out  WIDTH  offending target

## Operation
The block is a four-state FSM: BOOT, ISSUE, STALL, HOLD.
- **Reset:** state=BOOT; if_addr_o=RESET_VECTOR; if_req_o=0; fetch_valid_o=0; fetch_pc_o=RESET_VECTOR; adel_o=0; badvaddr_o=0; pending buffer empty.
- **BOOT:** moves to ISSUE unconditionally on the next edge.
- **ISSUE:** if_req_o=1.
  - If if_ready_i=0: if_addr_o holds stable. Redirects are captured into the pending buffer.
  - If if_ready_i=1: the fetch is accepted. The next address is selected in this order: same-cycle flush_i, then pending flush, then same-cycle branch_i, then pending branch, then if_addr_o+STEP. The pending buffer is cleared. If stall_i=1 (and no flush), the next state is STALL.
- **Pending buffer:** one flush slot plus one branch slot.
  - A newer flush overwrites an older flush.
  - A flush discards any pending branch.
  - A branch arriving while a flush is pending is ignored.
- **STALL:** if_req_o=0.
  - Redirects update if_addr_o directly, using the same priority.
  - stall_i=0 returns the FSM to ISSUE.
  - flush_i forces ISSUE regardless of stall_i.
- **HOLD:** if_req_o=0. Entered only through the alignment check. It is left only via flush_i, which loads flush_pc_i and goes to ISSUE.
- **Arithmetic:** addition is modulo 2^WIDTH; 32'hFFFFFFFC+4 wraps to 0 with no flag.

## Timing
- Reset to first request: 1 cycle (BOOT), so if_req_o=1 in the second cycle after rst deasserts.
- Accepted request to next request: 0 bubbles when if_ready_i stays high and there is no stall. Sustained throughput is one fetch per cycle.
- Redirect latency:
  - A redirect in an accepting cycle appears on if_addr_o at the next edge.
  - A redirect during a non-accepting cycle appears on the cycle after acceptance.
- fetch_valid_o/fetch_pc_o are registered one cycle after acceptance.
- rst asserted mid-request drops if_req_o immediately (asynchronous) and discards pending redirects.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A redirect target (flush or branch) with nonzero bits [log2(STEP)-1:0] is not issued.
  - Instead, adel_o pulses for 1 cycle, badvaddr_o latches the target, and the FSM enters HOLD.
  - Flush targets are also checked; a misaligned flush target causes HOLD again.
- PC_ALIGN_CHECK_EN undefined:
  - Targets are used as-is; the HOLD state is unreachable.
  - adel_o is tied 0 and badvaddr_o is tied 0.
  - Ports are present in both builds.

## Structure
- Shared package pc_pkg holds:
  - the state enum (BOOT, ISSUE, STALL, HOLD);
  - the default RESET_VECTOR and STEP constants;
  - the redirect-source encoding used by the pending buffer.
- One sub-module, pc_redirect_buf: the two-slot pending-redirect register with capture/priority/clear logic. The FSM and address register stay in pc_fetch_ctrl.

## Test plan
- Reset release with if_ready_i=1 throughout -> requests at BFC00000, BFC00004, BFC00008 on consecutive cycles; fetch_valid_o pulses one cycle behind each.
- if_ready_i=0 for 3 cycles at BFC00004, with branch_i (target 80001000) in the 2nd cycle -> if_addr_o stays BFC00004 until accepted, then 80001000.
- branch_i (80002000) and flush_i (BFC00380) pending in the same stall window -> next address BFC00380; the branch is never issued.
- stall_i for 2 cycles, then flush_i (BFC00380) while stalled -> if_req_o returns high with BFC00380 on the next cycle, stall ignored.
- With PC_ALIGN_CHECK_EN: branch target 80001002 -> adel_o pulse, badvaddr_o=80001002, if_req_o=0 until flush_i (BFC00380), then fetch resumes at BFC00380.
- Sequential wrap: start at FFFFFFF8 via flush -> requests FFFFFFF8, FFFFFFFC, 00000000.
